// File: rtl/the_data_memory.sv
// the_data_memory
// Quad-port data RAM for the pipelined AAP core: four independent combinational
// read ports and four synchronous write ports over a 512 x 32-bit word array.
// Simultaneous writes to one address resolve in favour of the highest-numbered
// port. An active-low asynchronous reset clears the whole array.

module the_data_memory #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] data_rd1,
    input  logic [ADDR_WIDTH-1:0] data_rd2,
    input  logic [ADDR_WIDTH-1:0] data_rd3,
    input  logic [ADDR_WIDTH-1:0] data_rd4,

    input  logic [ADDR_WIDTH-1:0] data_wr1,
    input  logic [ADDR_WIDTH-1:0] data_wr2,
    input  logic [ADDR_WIDTH-1:0] data_wr3,
    input  logic [ADDR_WIDTH-1:0] data_wr4,

    input  logic [DATA_WIDTH-1:0] data_wr1_data,
    input  logic [DATA_WIDTH-1:0] data_wr2_data,
    input  logic [DATA_WIDTH-1:0] data_wr3_data,
    input  logic [DATA_WIDTH-1:0] data_wr4_data,

    input  logic                  data_wr1_enable,
    input  logic                  data_wr2_enable,
    input  logic                  data_wr3_enable,
    input  logic                  data_wr4_enable,

    output logic [DATA_WIDTH-1:0] data_rd1_out,
    output logic [DATA_WIDTH-1:0] data_rd2_out,
    output logic [DATA_WIDTH-1:0] data_rd3_out,
    output logic [DATA_WIDTH-1:0] data_rd4_out
);

    localparam int NUM_WR_PORTS = 4;

    // Storage array.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write ports gathered into arrays so the commit loop can walk them in
    // port order; index 0 is port 1, index 3 is port 4.
    logic [ADDR_WIDTH-1:0] w_wrAddr  [0:NUM_WR_PORTS-1];
    logic [DATA_WIDTH-1:0] w_wrData  [0:NUM_WR_PORTS-1];
    logic                  w_wrEnable[0:NUM_WR_PORTS-1];
    logic                  w_wrCommit[0:NUM_WR_PORTS-1];

    assign w_wrAddr[0]   = data_wr1;
    assign w_wrAddr[1]   = data_wr2;
    assign w_wrAddr[2]   = data_wr3;
    assign w_wrAddr[3]   = data_wr4;

    assign w_wrData[0]   = data_wr1_data;
    assign w_wrData[1]   = data_wr2_data;
    assign w_wrData[2]   = data_wr3_data;
    assign w_wrData[3]   = data_wr4_data;

    assign w_wrEnable[0] = data_wr1_enable;
    assign w_wrEnable[1] = data_wr2_enable;
    assign w_wrEnable[2] = data_wr3_enable;
    assign w_wrEnable[3] = data_wr4_enable;

    // A port commits only when enabled and its address is fully known; an
    // X/Z address in simulation must not corrupt an arbitrary word. Synthesis
    // treats the unknown check as always false, leaving just the enable.
    always_comb begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            w_wrCommit[p] = w_wrEnable[p] && !$isunknown(w_wrAddr[p]);
        end
    end

    // Clear on reset; otherwise commit ports in ascending order so a later
    // (higher-numbered) port overrides an earlier one on the same address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (w_wrCommit[p]) begin
                    r_mem[w_wrAddr[p]] <= w_wrData[p];
                end
            end
        end
    end

    // Zero-latency reads. Outputs are forced to zero while reset is held so
    // they are already clean during the asynchronous clear.
    always_comb begin
        data_rd1_out = '0;
        data_rd2_out = '0;
        data_rd3_out = '0;
        data_rd4_out = '0;
        if (reset) begin
            data_rd1_out = r_mem[data_rd1];
            data_rd2_out = r_mem[data_rd2];
            data_rd3_out = r_mem[data_rd3];
            data_rd4_out = r_mem[data_rd4];
        end
    end

endmodule

// File: tb/tb_the_data_memory.sv
// tb_the_data_memory
// Scoreboard bench for the quad-port data RAM. The stimulus process drives a
// cycle, predicts the four read results from a plain array model and queues
// them; a monitor on the falling edge pops and compares against the outputs.

module tb_the_data_memory;

    logic        clock;
    logic        reset;
    logic [8:0]  rdAddr   [0:3];
    logic [8:0]  wrAddr   [0:3];
    logic [31:0] wrData   [0:3];
    logic        wrEnable [0:3];
    logic [31:0] rdOut    [0:3];

    typedef struct {
        int          port;
        logic [8:0]  addr;
        logic [31:0] expected;
        string       tag;
    } ExpectT;

    ExpectT      scoreQ[$];
    logic [31:0] model [0:511];
    int          compared;
    int          mismatched;

    the_data_memory dut (
        .clock            (clock),
        .reset            (reset),
        .data_rd1         (rdAddr[0]),
        .data_rd2         (rdAddr[1]),
        .data_rd3         (rdAddr[2]),
        .data_rd4         (rdAddr[3]),
        .data_wr1         (wrAddr[0]),
        .data_wr2         (wrAddr[1]),
        .data_wr3         (wrAddr[2]),
        .data_wr4         (wrAddr[3]),
        .data_wr1_data    (wrData[0]),
        .data_wr2_data    (wrData[1]),
        .data_wr3_data    (wrData[2]),
        .data_wr4_data    (wrData[3]),
        .data_wr1_enable  (wrEnable[0]),
        .data_wr2_enable  (wrEnable[1]),
        .data_wr3_enable  (wrEnable[2]),
        .data_wr4_enable  (wrEnable[3]),
        .data_rd1_out     (rdOut[0]),
        .data_rd2_out     (rdOut[1]),
        .data_rd3_out     (rdOut[2]),
        .data_rd4_out     (rdOut[3])
    );

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Queue the model's view of the four current read addresses.
    task automatic pushReads(input string tag);
        for (int p = 0; p < 4; p++) begin
            ExpectT e;
            e.port     = p;
            e.addr     = rdAddr[p];
            e.expected = reset ? model[rdAddr[p]] : 32'h0;
            e.tag      = tag;
            scoreQ.push_back(e);
        end
    endtask

    // Drive one cycle (called just after a rising edge), queue expectations,
    // then apply the writes to the model at the following edge.
    task automatic applyStimulus(input string tag);
        pushReads(tag);
        @(posedge clock);
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                if (wrEnable[p]) model[wrAddr[p]] = wrData[p];
            end
        end
        #1;
    endtask

    task automatic setReads(input int a0, input int a1, input int a2, input int a3);
        rdAddr[0] = 9'(a0); rdAddr[1] = 9'(a1); rdAddr[2] = 9'(a2); rdAddr[3] = 9'(a3);
    endtask

    task automatic clearWrites();
        for (int p = 0; p < 4; p++) begin
            wrEnable[p] = 1'b0;
            wrAddr[p]   = 9'($urandom_range(0, 511));
            wrData[p]   = $urandom;
        end
    endtask

    task automatic setWrite(input int p, input int a, input logic [31:0] d);
        wrAddr[p]   = 9'(a);
        wrData[p]   = d;
        wrEnable[p] = 1'b1;
    endtask

    function automatic logic [8:0] pickAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5)       return 9'($urandom_range(0, 7));
        else if (sel == 5) return 9'($urandom_range(508, 511));
        else               return 9'($urandom_range(0, 511));
    endfunction

    // Monitor: on each falling edge, compare every queued expectation.
    task automatic checkOutput();
        while (scoreQ.size() > 0) begin
            ExpectT e;
            e = scoreQ.pop_front();
            compared++;
            if (rdOut[e.port] !== e.expected) begin
                mismatched++;
                $display("[TB] FAIL %s rd%0d addr=%0d got=%h expected=%h",
                         e.tag, e.port + 1, e.addr, rdOut[e.port], e.expected);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        forever begin
            @(negedge clock);
            checkOutput();
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout compared=%0d", compared);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) model[i] = 32'h0;
        reset = 1'b0;
        clearWrites();
        setReads(0, 1, 255, 511);
        repeat (2) @(posedge clock);
        #1;
        applyStimulus("reset_state");
        reset = 1'b1;

        // Preload, then pulse reset low mid-cycle.
        clearWrites();
        setWrite(0, 0, 32'hCAFE0001); setWrite(1, 1, 32'hCAFE0002);
        setWrite(2, 255, 32'hCAFE0003); setWrite(3, 511, 32'hCAFE0004);
        applyStimulus("preload_before");
        clearWrites();
        applyStimulus("preload_after");
        setWrite(0, 1, 32'h0BAD0BAD);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) model[i] = 32'h0;
        applyStimulus("reset_pulse");
        reset = 1'b1;
        clearWrites();
        applyStimulus("after_reset");

        // Single write/read at 5.
        setReads(5, 5, 6, 4);
        setWrite(0, 5, 32'hDEADBEEF);
        applyStimulus("single_before_edge");
        clearWrites();
        applyStimulus("single_after_edge");

        // Parallel writes on four addresses.
        setReads(1, 2, 3, 4);
        setWrite(0, 1, 32'd11); setWrite(1, 2, 32'd22);
        setWrite(2, 3, 32'd33); setWrite(3, 4, 32'd44);
        applyStimulus("parallel_before");
        clearWrites();
        applyStimulus("parallel_after");

        // Collision wr2 vs wr4 at 7, then wr1 alone.
        setReads(7, 7, 7, 7);
        setWrite(1, 7, 32'hAAAA0000); setWrite(3, 7, 32'h5555FFFF);
        applyStimulus("collision_before");
        clearWrites();
        setWrite(0, 7, 32'h01010101);
        applyStimulus("collision_wr4_wins");
        clearWrites();
        applyStimulus("collision_wr1_over");

        // Disabled write leaves mem[7] unchanged.
        wrAddr[0] = 9'd7; wrData[0] = 32'h12345678; wrEnable[0] = 1'b0;
        applyStimulus("disabled_write");
        applyStimulus("disabled_after");

        // Boundary addresses.
        setReads(511, 0, 510, 1);
        setWrite(0, 511, 32'hFFFFFFFF); setWrite(1, 0, 32'h1);
        applyStimulus("boundary_before");
        clearWrites();
        applyStimulus("boundary_after");

        // Randomized traffic, dense in a small window to force collisions.
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 4; p++) begin
                rdAddr[p]   = pickAddr();
                wrAddr[p]   = pickAddr();
                wrData[p]   = $urandom;
                wrEnable[p] = ($urandom_range(0, 2) != 0);
            end
            applyStimulus("random");
        end

        // Drain scoreboard with a bounded wait.
        clearWrites();
        for (int k = 0; k < 5 && scoreQ.size() > 0; k++) @(posedge clock);
        if (scoreQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain pending=%0d expected=0", scoreQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
